// File: rtl/sdecc_pkg.sv
// Shared types for the SECDED error-capture path: codeword width and the
// penalty-box FIFO entry layout (address + raw codeword).
package sdecc_pkg;

  localparam int unsigned CODEWORD_W  = 72;
  localparam int unsigned PBOX_ADDR_W = 32;

  typedef struct packed {
    logic [PBOX_ADDR_W-1:0] addr;
    logic [CODEWORD_W-1:0]  codeword;
  } pbox_entry_t;

endpackage

// File: rtl/pbox_fifo.sv
// pbox_fifo: DEPTH-entry first-word-fall-through FIFO of pbox_entry_t.
// The head entry is held in a register, so it stays at its last value
// while the FIFO is empty and resets to zero.
// With PENALTY_BOX_DEDUP_EN defined, the stored addresses and a per-slot
// occupancy mask are exported for duplicate detection upstream.
module pbox_fifo
  import sdecc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pbox_entry_t push_data,
  input  logic        pop,
  output pbox_entry_t head,
  output logic        head_valid,
  output logic        full
`ifdef PENALTY_BOX_DEDUP_EN
  ,
  output logic [DEPTH-1:0][PBOX_ADDR_W-1:0] slot_addr,
  output logic [DEPTH-1:0]                  occupied
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  pbox_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count_nxt;

  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & (count != '0);
  assign do_push = push & (~full | do_pop);

  // Next read pointer and occupancy after this cycle's push/pop.
  always_comb begin
    rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  // Entry storage; contents are only meaningful where occupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, count and registered head. The head is loaded from the slot
  // the next read pointer addresses; when that slot is being written this
  // same cycle, the incoming data is forwarded instead of the stale slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        head <= (do_push && (wr_ptr == rd_ptr_nxt)) ? push_data : mem[rd_ptr_nxt];
      end
    end
  end

`ifdef PENALTY_BOX_DEDUP_EN
  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    slot_addr = '0;
    occupied  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_addr[i] = mem[i].addr;
      occupied[i]  = ({1'b0, AW'(i) - rd_ptr} < count);
    end
  end
`endif

endmodule

// File: rtl/penalty_box_capture.sv
// penalty_box_capture: captures every DUE-flagged codeword and its address
// into a small FWFT FIFO drained over valid/ready, and tracks DUEs dropped
// because the FIFO was full (sticky overflow + saturating drop counter).
// Optional macro PENALTY_BOX_DEDUP_EN: a DUE whose address matches any
// stored entry is silently discarded (not counted as a drop).
module penalty_box_capture
  import sdecc_pkg::*;
#(
  parameter int unsigned WIDTH  = 72,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_due,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [WIDTH-1:0]  in_codeword,
  output logic              full,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [WIDTH-1:0]  out_codeword,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count,
  input  logic              clear_overflow
);

  logic        push_req;
  logic        pop;
  logic        dup;
  logic        accept;
  logic        drop;
  pbox_entry_t push_data;
  pbox_entry_t head;

  assign push_req           = in_valid & in_due;
  assign pop                = out_valid & out_ready;
  assign push_data.addr     = in_addr;
  assign push_data.codeword = in_codeword;
  assign out_addr           = head.addr;
  assign out_codeword       = head.codeword;

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign accept = push_req & ~dup & (~full | pop);
  assign drop   = push_req & ~dup & full & ~pop;

`ifdef PENALTY_BOX_DEDUP_EN
  logic [DEPTH-1:0][ADDR_W-1:0] slot_addr;
  logic [DEPTH-1:0]             occupied;

  // Match against registered storage only; a same-cycle push is not seen.
  always_comb begin
    dup = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (slot_addr[i] == in_addr)) begin
        dup = 1'b1;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  pbox_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .head_valid (out_valid),
    .full       (full)
`ifdef PENALTY_BOX_DEDUP_EN
    ,
    .slot_addr  (slot_addr),
    .occupied   (occupied)
`endif
  );

  // Sticky overflow and saturating drop count; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_count <= CNT_W'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_penalty_box_capture.sv
// Self-checking bench for penalty_box_capture against a queue-based model.
module tb_penalty_box_capture;

  localparam int DEPTH = 4;
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_due = 1'b0;
  logic [31:0] in_addr = '0;
  logic [71:0] in_codeword = '0;
  logic        full;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [71:0] out_codeword;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clear_overflow = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [71:0] c;
  } ent_t;

  ent_t m_q[$];
  bit   m_ovf;
  int   m_drop;

  penalty_box_capture #(
    .WIDTH  (72),
    .ADDR_W (32),
    .DEPTH  (DEPTH),
    .CNT_W  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_due         (in_due),
    .in_addr        (in_addr),
    .in_codeword    (in_codeword),
    .full           (full),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_codeword   (out_codeword),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] rand_cw();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle of inputs, advance the reference model, sample after the edge.
  task automatic cycle(input logic v, input logic d, input logic [31:0] a,
                       input logic [71:0] c, input logic rdy, input logic clr,
                       input logic r);
    bit   do_pop, preq, dup, acc, drp;
    ent_t e;
    rst = r; in_valid = v; in_due = d; in_addr = a; in_codeword = c;
    out_ready = rdy; clear_overflow = clr;
    if (r) begin
      m_q.delete();
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      do_pop = (m_q.size() > 0) && rdy;
      preq   = v && d;
      dup    = 0;
`ifdef PENALTY_BOX_DEDUP_EN
      foreach (m_q[i]) if (m_q[i].a == a) dup = 1;
`endif
      acc = preq && !dup && ((m_q.size() < DEPTH) || do_pop);
      drp = preq && !dup && !acc;
      if (do_pop) void'(m_q.pop_front());
      if (acc) begin
        e.a = a;
        e.c = c;
        m_q.push_back(e);
      end
      if (drp) begin
        m_ovf  = 1;
        m_drop = clr ? 1 : ((m_drop < CNT_MAX) ? m_drop + 1 : CNT_MAX);
      end else if (clr) begin
        m_ovf  = 0;
        m_drop = 0;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_due = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 1, 32'h55, rand_cw(), 1, 0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    checks++; if (out_addr !== 32'd0) begin errors++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
    checks++; if (out_codeword !== 72'd0) begin errors++; $display("FAIL reset_out_codeword: got %h want 0", out_codeword); end
  endtask

  task automatic test_single_due();
    cycle(1, 1, 32'h1000, 72'hAB_0123456789ABCDEF, 0, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_addr !== 32'h1000) begin errors++; $display("FAIL single_addr: got %h want 00001000", out_addr); end
    checks++; if (out_codeword !== 72'hAB_0123456789ABCDEF) begin errors++; $display("FAIL single_cw: got %h want ab0123456789abcdef", out_codeword); end
    cycle(0, 0, 0, 0, 1, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_non_due();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, $urandom(), rand_cw(), $urandom_range(0, 1), 0, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL non_due_valid[%0d]: got %b want 0", i, out_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL non_due_overflow[%0d]: got %b want 0", i, overflow); end
    end
  endtask

  task automatic test_fill_overflow();
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, i, rand_cw(), 0, 0, 0);
      if (i == 3) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow_yet: got %b want 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b want 1", overflow); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL fill_drop_count: got %0d want 2", drop_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_addr !== 32'(i)) begin errors++; $display("FAIL drain_addr[%0d]: got %h want %h", i, out_addr, 32'(i)); end
      checks++; if (out_codeword !== m_q[0].c) begin errors++; $display("FAIL drain_cw[%0d]: got %h want %h", i, out_codeword, m_q[0].c); end
      cycle(0, 0, 0, 0, 1, 0, 0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_not_full: got %b want 0", full); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_order [4];
    exp_order[0] = 32'h11; exp_order[1] = 32'h12; exp_order[2] = 32'h13; exp_order[3] = 32'h9;
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h10 + i, rand_cw(), 0, 0, 0);
    // Hold a non-ready cycle to confirm head stability while full.
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_addr !== 32'h10) begin errors++; $display("FAIL hold_addr: got %h want 00000010", out_addr); end
    cycle(1, 1, 32'h9, rand_cw(), 1, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL pushpop_full: got %b want 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow: got %b want 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL pushpop_drop: got %0d want 0", drop_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_addr !== exp_order[i]) begin errors++; $display("FAIL pushpop_order[%0d]: got %h want %h", i, out_addr, exp_order[i]); end
      cycle(0, 0, 0, 0, 1, 0, 0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_saturation_clear();
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h20 + i, rand_cw(), 0, 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 1, 32'h100 + i, rand_cw(), 0, 0, 0);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_drop_count: got %0d want 255", drop_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b want 1", overflow); end
    cycle(1, 1, 32'h500, rand_cw(), 0, 1, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clear_drop_overflow: got %b want 1", overflow); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL clear_drop_count: got %0d want 1", drop_count); end
    cycle(0, 0, 0, 0, 0, 1, 0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b want 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL clear_count: got %0d want 0", drop_count); end
  endtask

  task automatic test_reset_mid_drain();
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h30 + i, rand_cw(), 0, 0, 0);
    cycle(1, 1, 32'h40, rand_cw(), 1, 0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b want 0", full); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL midrst_drop: got %0d want 0", drop_count); end
    cycle(1, 1, 32'h77, 72'h5A, 0, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_push_valid: got %b want 1", out_valid); end
    checks++; if (out_addr !== 32'h77) begin errors++; $display("FAIL midrst_push_addr: got %h want 00000077", out_addr); end
    cycle(0, 0, 0, 0, 1, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [7:0] exp_cnt;
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom() % 4) != 0, $urandom_range(0, 1), $urandom_range(0, 7), rand_cw(),
            ($urandom() % 3) == 0, ($urandom() % 16) == 0, 0);
      exp_cnt = m_drop[7:0];
      checks++; if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, m_q.size() != 0); end
      checks++; if (full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full[%0d]: got %b want %b", n, full, m_q.size() == DEPTH); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow[%0d]: got %b want %b", n, overflow, m_ovf); end
      checks++; if (drop_count !== exp_cnt) begin errors++; $display("FAIL rnd_drop[%0d]: got %0d want %0d", n, drop_count, exp_cnt); end
      if (m_q.size() != 0) begin
        checks++; if (out_addr !== m_q[0].a) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, out_addr, m_q[0].a); end
        checks++; if (out_codeword !== m_q[0].c) begin errors++; $display("FAIL rnd_cw[%0d]: got %h want %h", n, out_codeword, m_q[0].c); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_due();
    test_non_due();
    test_fill_overflow();
    test_full_push_pop();
    test_saturation_clear();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/penalty_box_capture.md
Name: penalty_box_capture

Overview:
- Sits directly downstream of the 72-bit codeword latch stage and the SECDED decoder's error flags.
- Captures every codeword flagged as a detected-but-uncorrectable error (DUE), together with its address, into a small FIFO (the "penalty box").
- Recovery software or the firmware-side recovery engine drains the FIFO over a valid/ready interface.
- Tracks overflow when DUEs arrive faster than they are drained.

Parameters:
- WIDTH, 72, codeword width (64 data + 8 check bits).
- ADDR_W, 32, width of the captured access address.
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  codeword/flags on the inputs are valid this cycle.
- in_due  input  1  decoder flagged a DUE for this codeword.
- in_addr  input  ADDR_W  address of the access.
- in_codeword  input  WIDTH  raw 72-bit codeword from the upstream latch.
- full  output  1  FIFO holds DEPTH entries.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_addr  output  ADDR_W  head entry address.
- out_codeword  output  WIDTH  head entry codeword.
- overflow  output  1  sticky flag: at least one DUE was dropped.
- drop_count  output  CNT_W  saturating count of dropped DUEs.
- clear_overflow  input  1  clears overflow and drop_count.

Behaviour:
- Reset (rst=1 at a clock edge) has the following effect:
  - Pointers and count go to 0.
  - full=0, out_valid=0, overflow=0, drop_count=0.
  - out_addr and out_codeword go to 0.
  - Reset mid-operation discards all entries; there is no partial drain.
- Push and pop conditions:
  - push_req = in_valid & in_due. When in_valid=0, in_due is ignored.
  - pop = out_valid & out_ready.
- Push acceptance: a push is accepted when count<DEPTH, or when count==DEPTH and pop is asserted in the same cycle. Simultaneous push and pop on a full FIFO therefore accepts the push, and count stays at DEPTH.
- Drop: a push_req that is not accepted is dropped.
  - overflow is set.
  - drop_count increments and saturates at 2^CNT_W-1; it never wraps.
- Clear:
  - clear_overflow=1 zeroes overflow and drop_count.
  - If a drop occurs in the same cycle as a clear, the drop wins: overflow=1 and drop_count=1.
- Output timing:
  - Output is first-word-fall-through from registered storage.
  - An entry accepted at edge N is visible at out_* with out_valid=1 after edge N.
  - Latency from capture to visibility is 1 cycle.
- Output stability: while out_valid=1 and out_ready=0, out_addr and out_codeword hold stable.
- Empty FIFO:
  - out_valid=0; out_* hold their last values (do-not-care to the consumer).
  - A push into an empty FIFO with out_ready=1 in the same cycle does not bypass; the entry appears next cycle.
- Ordering: strict FIFO. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- full = (count==DEPTH), derived from the registered count.

Optional Feature:
- Macro: PENALTY_BOX_DEDUP_EN.
- Defined:
  - A push_req whose in_addr equals the address of any valid stored entry is discarded.
  - It is not counted as a drop and does not set overflow.
  - Comparison is against registered storage only, not against a push in the same cycle.
- Undefined: every DUE is captured, including repeats of the same address; the comparison logic is absent.

Decomposition:
- Package sdecc_pkg holds:
  - CODEWORD_W=72 constant.
  - Typedef pbox_entry_t, a packed struct {addr, codeword}.
- Sub-module pbox_fifo: a generic DEPTH-entry FWFT FIFO of pbox_entry_t with push/pop/count.
- Top level owns the DUE qualification, overflow and drop counter, and dedup logic.

Test Plan:
- Reset then single DUE:
  - Stimulus: in_valid=1, in_due=1, addr=0x1000, cw=72'hAB_0123456789ABCDEF.
  - Response: next cycle out_valid=1 with matching out_*. With out_ready=1, out_valid=0 one cycle later.
- Non-DUE traffic:
  - Stimulus: 10 cycles of in_valid=1, in_due=0.
  - Response: out_valid stays 0, overflow=0.
- Fill and overflow:
  - Stimulus: with out_ready=0, push 6 DUEs at addrs 0x0..0x5.
  - Response: full=1 after the 4th, overflow=1, drop_count=2. Drain returns 0x0..0x3 in order.
- Full with simultaneous push and pop:
  - Stimulus: push addr 0x9 while full with out_ready=1.
  - Response: push accepted, count stays 4, no drop. 0x9 is last out.
- Saturation and clear:
  - Stimulus: CNT_W=8, 300 drops.
  - Response: drop_count=255.
  - Stimulus: clear_overflow with a concurrent drop.
  - Response: overflow=1, drop_count=1.
- Reset mid-drain:
  - Stimulus: assert rst with 3 entries held.
  - Response: next cycle out_valid=0, full=0, drop_count=0. A subsequent push appears normally.
